// File: rtl/alu_mc_pkg.sv
// alu_mc shared definitions: widths, opcodes, FSM state encoding and
// the single-cycle ALU function. Build option: ALU_MC_FAST_MUL_EN.
package alu_mc_pkg;

    localparam int DATA_WIDTH           = 32;
    localparam int DATA_INDEX_LIMIT     = DATA_WIDTH - 1;
    localparam int ALU_OPRN_WIDTH       = 6;
    localparam int ALU_OPRN_INDEX_LIMIT = ALU_OPRN_WIDTH - 1;
    localparam int SHAMT_WIDTH          = $clog2(DATA_WIDTH);

    localparam logic [ALU_OPRN_INDEX_LIMIT:0] OPRN_ADD = 6'h01;
    localparam logic [ALU_OPRN_INDEX_LIMIT:0] OPRN_SUB = 6'h02;
    localparam logic [ALU_OPRN_INDEX_LIMIT:0] OPRN_MUL = 6'h03;
    localparam logic [ALU_OPRN_INDEX_LIMIT:0] OPRN_SHR = 6'h04;
    localparam logic [ALU_OPRN_INDEX_LIMIT:0] OPRN_SHL = 6'h05;
    localparam logic [ALU_OPRN_INDEX_LIMIT:0] OPRN_AND = 6'h06;
    localparam logic [ALU_OPRN_INDEX_LIMIT:0] OPRN_OR  = 6'h07;
    localparam logic [ALU_OPRN_INDEX_LIMIT:0] OPRN_NOR = 6'h08;
    localparam logic [ALU_OPRN_INDEX_LIMIT:0] OPRN_SLT = 6'h09;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    // Single-cycle result. Unknown opcodes yield 0. Multiply only
    // appears here in the combinational-multiply build.
    function automatic logic [DATA_INDEX_LIMIT:0] alu_calc(
        input logic [DATA_INDEX_LIMIT:0]     a,
        input logic [DATA_INDEX_LIMIT:0]     b,
        input logic [ALU_OPRN_INDEX_LIMIT:0] op
    );
        logic [DATA_INDEX_LIMIT:0] r;
        logic                      big_shamt;
        big_shamt = (b[DATA_INDEX_LIMIT:SHAMT_WIDTH] != '0);
        r = '0;
        case (op)
            OPRN_ADD: r = a + b;
            OPRN_SUB: r = a - b;
`ifdef ALU_MC_FAST_MUL_EN
            OPRN_MUL: r = a * b;
`endif
            OPRN_SHR: r = big_shamt ? '0 : (a >> b[SHAMT_WIDTH-1:0]);
            OPRN_SHL: r = big_shamt ? '0 : (a << b[SHAMT_WIDTH-1:0]);
            OPRN_AND: r = a & b;
            OPRN_OR:  r = a | b;
            OPRN_NOR: r = ~(a | b);
            OPRN_SLT: r = {{DATA_INDEX_LIMIT{1'b0}}, (a < b)};
            default:  r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier datapath, one partial product per step.
// Ports: clk, rst (sync, active-high), load, step, op1, op2 -> last, result.
module alu_mul_iter
    import alu_mc_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic                      step,
    input  logic [DATA_INDEX_LIMIT:0] op1,
    input  logic [DATA_INDEX_LIMIT:0] op2,
    output logic                      last,
    output logic [DATA_INDEX_LIMIT:0] result
);

    localparam logic [SHAMT_WIDTH-1:0] CNT_LAST =
        SHAMT_WIDTH'(DATA_INDEX_LIMIT);

    logic [DATA_INDEX_LIMIT:0] acc_q, acc_d;
    logic [DATA_INDEX_LIMIT:0] mcand_q, mcand_d;
    logic [DATA_INDEX_LIMIT:0] mplier_q, mplier_d;
    logic [SHAMT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [DATA_INDEX_LIMIT:0] sum;

    // sum already contains this step's partial product, so on the last
    // step it is the finished (truncated) product.
    assign sum    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign result = sum;
    assign last   = (cnt_q == CNT_LAST);

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (load) begin
            acc_d    = '0;
            mcand_d  = op1;
            mplier_d = op2;
            cnt_d    = '0;
        end else if (step) begin
            acc_d    = sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Handshaked multi-cycle ALU: START latches OP1/OP2/OPRN, DONE pulses with
// registered OUT/ZERO. Inputs: CLK, RST (sync, active-high), START, OP1, OP2,
// OPRN. Outputs: BUSY, DONE, OUT, ZERO.
// Build option: ALU_MC_FAST_MUL_EN makes multiply single-cycle (no MUL state).
module alu_mc
    import alu_mc_pkg::*;
(
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          START,
    input  logic [DATA_INDEX_LIMIT:0]     OP1,
    input  logic [DATA_INDEX_LIMIT:0]     OP2,
    input  logic [ALU_OPRN_INDEX_LIMIT:0] OPRN,
    output logic                          BUSY,
    output logic                          DONE,
    output logic [DATA_INDEX_LIMIT:0]     OUT,
    output logic                          ZERO
);

    logic                      done_q, done_d;
    logic [DATA_INDEX_LIMIT:0] out_q, out_d;
    logic                      zero_q, zero_d;

`ifndef ALU_MC_FAST_MUL_EN
    state_t                    state_q, state_d;
    logic                      mul_load;
    logic                      mul_step;
    logic                      mul_last;
    logic [DATA_INDEX_LIMIT:0] mul_result;

    alu_mul_iter u_mul (
        .clk    (CLK),
        .rst    (RST),
        .load   (mul_load),
        .step   (mul_step),
        .op1    (OP1),
        .op2    (OP2),
        .last   (mul_last),
        .result (mul_result)
    );

    always_comb begin
        state_d  = state_q;
        done_d   = 1'b0;
        out_d    = out_q;
        zero_d   = zero_q;
        mul_load = 1'b0;
        mul_step = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (START) begin
                    if (OPRN == OPRN_MUL) begin
                        mul_load = 1'b1;
                        state_d  = ST_MUL;
                    end else begin
                        out_d  = alu_calc(OP1, OP2, OPRN);
                        zero_d = (out_d == '0);
                        done_d = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                // START and operand inputs are ignored until completion.
                mul_step = 1'b1;
                if (mul_last) begin
                    out_d   = mul_result;
                    zero_d  = (out_d == '0);
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    assign BUSY = (state_q == ST_MUL);
`else
    always_comb begin
        done_d = 1'b0;
        out_d  = out_q;
        zero_d = zero_q;
        if (START) begin
            out_d  = alu_calc(OP1, OP2, OPRN);
            zero_d = (out_d == '0);
            done_d = 1'b1;
        end
    end

    assign BUSY = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            done_q <= 1'b0;
            out_q  <= '0;
            zero_q <= 1'b1;
        end else begin
            done_q <= done_d;
            out_q  <= out_d;
            zero_q <= zero_d;
        end
    end

    assign DONE = done_q;
    assign OUT  = out_q;
    assign ZERO = zero_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed cases plus random requests
// checked against an arithmetic reference model.
module tb_alu_mc;
    import alu_mc_pkg::*;

`ifdef ALU_MC_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic [31:0] OP1;
    logic [31:0] OP2;
    logic [5:0]  OPRN;
    logic        BUSY;
    logic        DONE;
    logic [31:0] OUT;
    logic        ZERO;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    alu_mc dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .OP1   (OP1),
        .OP2   (OP2),
        .OPRN  (OPRN),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .OUT   (OUT),
        .ZERO  (ZERO)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int op);
        logic [63:0] p;
        case (op)
            1: return a + b;
            2: return a - b;
            3: begin
                p = {32'd0, a} * {32'd0, b};
                return p[31:0];
            end
            4: return (b >= 32) ? 32'd0 : (a >> b);
            5: return (b >= 32) ? 32'd0 : (a << b);
            6: return a & b;
            7: return a | b;
            8: return ~(a | b);
            9: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [31:0] a,
                          input logic [31:0] b, input logic [5:0] op);
        logic [31:0] exp;
        int          exp_lat;
        int          lat;
        exp     = ref_alu(a, b, int'(op));
        exp_lat = (op == 6'h03) ? MUL_LAT : 1;
        OP1   = a;
        OP2   = b;
        OPRN  = op;
        START = 1'b1;
        tick();
        START = 1'b0;
        OP1   = $urandom;
        OP2   = $urandom;
        OPRN  = 6'($urandom);
        check({tag, "_busy0"}, 32'(BUSY), 32'(exp_lat > 1));
        lat = 1;
        while (!DONE && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, "_done"}, 32'(DONE), 32'd1);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_out"}, OUT, exp);
        check({tag, "_zero"}, 32'(ZERO), 32'(exp == 0));
        check({tag, "_busy1"}, 32'(BUSY), 32'd0);
        tick();
        check({tag, "_pulse"}, 32'(DONE), 32'd0);
        check({tag, "_hold"}, OUT, exp);
    endtask

    initial begin
        int          dones;
        int          done_cyc;
        logic [31:0] done_out;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [5:0]  rop;

        RST   = 1'b1;
        START = 1'b0;
        OP1   = '0;
        OP2   = '0;
        OPRN  = '0;
        tick();
        tick();
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        check("rst_out", OUT, 32'd0);
        check("rst_zero", 32'(ZERO), 32'd1);
        RST = 1'b0;
        tick();

        run_op("add", 32'd15, 32'd3, 6'h01);
        check("add_const", OUT, 32'd18);

        OP1 = 32'd15; OP2 = 32'd15; OPRN = 6'h02; START = 1'b1;
        tick();
        check("b2b_sub_done", 32'(DONE), 32'd1);
        check("b2b_sub_out", OUT, 32'd0);
        check("b2b_sub_zero", 32'(ZERO), 32'd1);
        OP1 = 32'd1; OP2 = 32'd5; OPRN = 6'h08;
        tick();
        check("b2b_nor_done", 32'(DONE), 32'd1);
        check("b2b_nor_out", OUT, 32'hFFFF_FFFA);
        check("b2b_nor_zero", 32'(ZERO), 32'd0);
        OP1 = 32'd10; OP2 = 32'd5; OPRN = 6'h09;
        tick();
        check("b2b_slt_done", 32'(DONE), 32'd1);
        check("b2b_slt_out", OUT, 32'd0);
        check("b2b_slt_zero", 32'(ZERO), 32'd1);
        START = 1'b0;
        tick();
        check("b2b_end", 32'(DONE), 32'd0);

        run_op("mul9x3", 32'd9, 32'd3, 6'h03);
        check("mul9x3_const", OUT, 32'd27);

`ifndef ALU_MC_FAST_MUL_EN
        OP1 = 32'd9; OP2 = 32'd3; OPRN = 6'h03; START = 1'b1;
        tick();
        dones    = 0;
        done_cyc = 0;
        done_out = '0;
        for (int c = 2; c <= 45; c++) begin
            START = (c == 10);
            OP1   = 32'd15;
            OP2   = 32'd5;
            OPRN  = 6'h01;
            tick();
            if (DONE) begin
                dones++;
                done_cyc = c;
                done_out = OUT;
            end
        end
        START = 1'b0;
        check("ign_dones", dones, 32'd1);
        check("ign_cycle", done_cyc, 32'd33);
        check("ign_out", done_out, 32'd27);
`endif

        run_op("mul_trunc", 32'h0001_0000, 32'h0001_0000, 6'h03);
        run_op("shr", 32'd12, 32'd2, 6'h04);
        run_op("shl", 32'd10, 32'd2, 6'h05);
        run_op("shl40", 32'd1, 32'd40, 6'h05);
        run_op("op3f", 32'd7, 32'd9, 6'h3F);
        run_op("op00", 32'd7, 32'd9, 6'h00);

`ifndef ALU_MC_FAST_MUL_EN
        run_op("pre_rst", 32'd15, 32'd3, 6'h01);
        OP1 = 32'd9; OP2 = 32'd3; OPRN = 6'h03; START = 1'b1;
        tick();
        START = 1'b0;
        for (int c = 2; c <= 14; c++) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("mrst_busy", 32'(BUSY), 32'd0);
        check("mrst_done", 32'(DONE), 32'd0);
        check("mrst_out", OUT, 32'd0);
        check("mrst_zero", 32'(ZERO), 32'd1);
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (DONE) dones++;
        end
        check("mrst_nodone", dones, 32'd0);
        run_op("post_rst", 32'd15, 32'd3, 6'h01);
`endif

        run_op("pre_rs", 32'd15, 32'd3, 6'h01);
        OP1 = 32'd1; OP2 = 32'd1; OPRN = 6'h01;
        START = 1'b1;
        RST   = 1'b1;
        tick();
        START = 1'b0;
        RST   = 1'b0;
        check("rs_done", 32'(DONE), 32'd0);
        check("rs_out", OUT, 32'd0);
        check("rs_zero", 32'(ZERO), 32'd1);
        tick();
        check("rs_after", 32'(DONE), 32'd0);

        for (int i = 0; i < 40; i++) begin
            ra  = $urandom;
            rb  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40))
                                              : $urandom;
            rop = 6'($urandom_range(0, 10));
            if (rop == 6'd10) rop = 6'($urandom);
            if ($urandom_range(0, 7) == 0) rb = ra;
            run_op($sformatf("rnd%0d", i), ra, rb, rop);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
